conn_tb_arbiter: RTL
====================

Name: conn_tb_arbiter

Overview:
- Shares the single port of the connection hash table or flow-key table between two requesters: the per-packet lookup path (LK) and the connection configuration engine (CF).
- One instance sits in front of each table in the connection manager.
- Arbitrates command slots, returns read data to the requester that issued the read, and bounds starvation of CF.
- Lets CF lock the port for atomic read-modify-write sequences such as hash-chain delete walks.

Parameters:
W_IDX, 3, table index width
W_DATA, 120, table entry width (17 for hashTb)
RD_LAT, 2, RAM read latency in cycles from ram_rdValid to ram_ctx valid
STARVE_MAX, 8, consecutive denied CF cycles before CF is forced a grant
LOCK_MAX, 64, maximum cycles CF may hold the lock

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
lk_req  in  1  LK command request; held with command until lk_gnt
lk_wr  in  1  1 = write, 0 = read
lk_idx  in  W_IDX  LK table index
lk_wdata  in  W_DATA  LK write data
lk_gnt  out  1  LK command accepted this cycle
lk_rvalid  out  1  LK read data valid
lk_rdata  out  W_DATA  LK read data
cf_req  in  1  CF command request
cf_wr  in  1  CF write select
cf_idx  in  W_IDX  CF table index
cf_wdata  in  W_DATA  CF write data
cf_lock  in  1  CF requests/holds exclusive ownership
cf_gnt  out  1  CF command accepted
cf_rvalid  out  1  CF read data valid
cf_rdata  out  W_DATA  CF read data
ram_idx  out  W_IDX  table index
ram_rdValid  out  1  table read strobe
ram_wrValid  out  1  table write strobe
ram_data  out  W_DATA  table write data
ram_ctx  in  W_DATA  table read data
lock_err  out  1  one-cycle pulse on forced lock release
starve_cnt  out  4  current CF starvation count

Behaviour:
- Reset: all outputs 0; state ARB_S; in-flight read tags cleared.
  - Reset mid-read: the pending read never produces rvalid.
- Grants: lk_gnt and cf_gnt are combinational from registered state and current requests.
  - At most one grant per cycle.
  - Granted command appears on ram_* the next cycle, registered.
  - ram_rdValid/ram_wrValid are 1-cycle pulses.
  - ram_idx and ram_data hold their last value when idle.
- ARB_S:
  - Only one req: grant it.
  - Both req: LK wins unless starve_cnt == STARVE_MAX, in which case CF wins.
  - starve_cnt increments (saturating at STARVE_MAX) each cycle cf_req=1 and cf_gnt=0; clears to 0 on cf_gnt.
  - CF granted with cf_lock=1: next state LOCK_S, lock counter cleared.
- LOCK_S:
  - lk_gnt forced 0; cf_req granted every cycle it is asserted.
  - Lock counter increments each cycle.
  - cf_lock=0: return to ARB_S the same cycle, so LK may be granted that cycle.
  - Lock counter reaches LOCK_MAX-1 with cf_lock still 1: pulse lock_err, return to ARB_S, ignore cf_lock until it has been seen low once.
- Read return: each granted read pushes an owner tag into an RD_LAT+1 stage shift register.
  - At the stage aligned with ram_ctx, assert the owner's rvalid for 1 cycle; rdata = ram_ctx.
  - Read response latency from grant to rvalid = RD_LAT+1 cycles (3 at default).
  - Back-to-back reads, including alternating owners, return in issue order, one per cycle.
  - Non-owner rdata holds its previous value.
- Hazards: commands execute in grant order.
  - A CF write granted after an LK read to the same index does not alter that read's returned data. The RAM is read-before-write across cycles; the arbiter adds no bypass.
- Writes produce no rvalid.
- lk_req or cf_req dropped before grant: no command issued, no error.

Decomposition:
- Shared package conn_pkg: owner tag encoding (TAG_NONE=0, TAG_LK=1, TAG_CF=2), arbiter state encoding (ARB_S, LOCK_S), default widths matching the hashTb and flowKTb formats.
- One natural sub-module, rd_tag_pipe: parameterised RD_LAT+1 shift register of {valid, owner}, cleared asynchronously on reset.

Test Plan:
- LK read idx=5 alone, ram_ctx returns 0x...AB → lk_gnt same cycle, ram_rdValid next cycle with ram_idx=5, lk_rvalid 3 cycles after grant with lk_rdata=0x...AB, cf_rvalid stays 0.
- lk_req and cf_req held continuously → LK granted 8 consecutive cycles, CF granted on cycle 9, starve_cnt reads 8 then 0, pattern repeats.
- CF read with cf_lock=1, then write idx=2 data=0x1_0003, then cf_lock=0 while lk_req held throughout → lk_gnt=0 during lock; LK granted the cycle cf_lock falls; RAM shows CF read, CF write, then LK command in that order.
- cf_lock held 70 cycles with lk_req=1 → lock_err pulses once at lock cycle 64, LK granted that cycle, no relock until cf_lock toggles low.
- Alternating LK/CF reads, idx 1,2,3,4 every cycle → rvalid alternates lk/cf in issue order, one per cycle, data matching ram_ctx per index.
- Assert reset one cycle after an LK read grant → no lk_rvalid ever asserted; all outputs 0 during reset; normal arbitration resumes after release.

Source files
------------

// File: rtl/conn_pkg.sv
// Shared types for the connection-table port arbiters: read-owner tags,
// arbiter states and the default entry widths of the two tables.
package conn_pkg;

  localparam int unsigned TB_W_IDX       = 3;
  localparam int unsigned HASHTB_W_DATA  = 17;
  localparam int unsigned FLOWKTB_W_DATA = 120;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_LK   = 2'd1,
    TAG_CF   = 2'd2
  } rd_owner_e;

  typedef struct packed {
    logic      vld;
    rd_owner_e owner;
  } rd_tag_t;

  typedef enum logic {
    ARB_S  = 1'b0,
    LOCK_S = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rd_tag_pipe.sv
// Shift register of read-owner tags; the last stage lines up with the
// cycle in which the table presents the read data.
module rd_tag_pipe
  import conn_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/conn_tb_arbiter.sv
// Two-requester arbiter (lookup path LK, config engine CF) in front of one
// connection table port, with CF starvation bound and CF exclusive lock.
module conn_tb_arbiter
  import conn_pkg::*;
#(
  parameter int unsigned W_IDX      = 3,
  parameter int unsigned W_DATA     = 120,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned LOCK_MAX   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lk_req,
  input  logic              lk_wr,
  input  logic [W_IDX-1:0]  lk_idx,
  input  logic [W_DATA-1:0] lk_wdata,
  output logic              lk_gnt,
  output logic              lk_rvalid,
  output logic [W_DATA-1:0] lk_rdata,
  input  logic              cf_req,
  input  logic              cf_wr,
  input  logic [W_IDX-1:0]  cf_idx,
  input  logic [W_DATA-1:0] cf_wdata,
  input  logic              cf_lock,
  output logic              cf_gnt,
  output logic              cf_rvalid,
  output logic [W_DATA-1:0] cf_rdata,
  output logic [W_IDX-1:0]  ram_idx,
  output logic              ram_rdValid,
  output logic              ram_wrValid,
  output logic [W_DATA-1:0] ram_data,
  input  logic [W_DATA-1:0] ram_ctx,
  output logic              lock_err,
  output logic [3:0]        starve_cnt
);

  localparam int unsigned LCW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  arb_state_e        state_q, state_d;
  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
  logic              ign_q, ign_d;
  logic [3:0]        starve_q, starve_d;
  logic              arb_mode;

  logic              gnt_any, cmd_wr;
  logic [W_IDX-1:0]  cmd_idx;
  logic [W_DATA-1:0] cmd_wdata;

  logic              rd_q, wr_q;
  logic [W_IDX-1:0]  idx_q;
  logic [W_DATA-1:0] data_q;
  logic [W_DATA-1:0] lk_hold_q, cf_hold_q;
  rd_tag_t           tag_in, tag_out;

  // A lock that is released or times out falls back to normal arbitration
  // in the same cycle, so LK can be granted immediately.
  always_comb begin
    state_d    = ARB_S;
    lock_cnt_d = lock_cnt_q;
    ign_d      = ign_q;
    starve_d   = starve_q;
    lock_err   = 1'b0;
    arb_mode   = 1'b1;
    lk_gnt     = 1'b0;
    cf_gnt     = 1'b0;

    if (state_q == LOCK_S && cf_lock) begin
      if (lock_cnt_q == LCW'(LOCK_MAX - 1)) begin
        lock_err = 1'b1;
        ign_d    = 1'b1;
      end else begin
        arb_mode   = 1'b0;
        state_d    = LOCK_S;
        lock_cnt_d = lock_cnt_q + LCW'(1);
      end
    end

    if (reset) begin
      if (!arb_mode) begin
        cf_gnt = cf_req;
      end else begin
        lk_gnt = lk_req && !(cf_req && starve_q == 4'(STARVE_MAX));
        cf_gnt = cf_req && !lk_gnt;
        if (cf_gnt && cf_lock && !ign_d) begin
          state_d    = LOCK_S;
          lock_cnt_d = '0;
        end
      end
    end

    if (!cf_lock) ign_d = 1'b0;

    if (cf_gnt) starve_d = '0;
    else if (cf_req && starve_q != 4'(STARVE_MAX)) starve_d = starve_q + 4'd1;
  end

  always_comb begin
    gnt_any      = lk_gnt | cf_gnt;
    cmd_wr       = cf_gnt ? cf_wr    : lk_wr;
    cmd_idx      = cf_gnt ? cf_idx   : lk_idx;
    cmd_wdata    = cf_gnt ? cf_wdata : lk_wdata;
    tag_in.vld   = gnt_any & ~cmd_wr;
    tag_in.owner = !tag_in.vld ? TAG_NONE : (cf_gnt ? TAG_CF : TAG_LK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_S;
      lock_cnt_q <= '0;
      ign_q      <= 1'b0;
      starve_q   <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
      lk_hold_q  <= '0;
      cf_hold_q  <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      ign_q      <= ign_d;
      starve_q   <= starve_d;
      rd_q       <= gnt_any & ~cmd_wr;
      wr_q       <= gnt_any & cmd_wr;
      if (gnt_any) idx_q <= cmd_idx;
      if (gnt_any && cmd_wr) data_q <= cmd_wdata;
      if (lk_rvalid) lk_hold_q <= ram_ctx;
      if (cf_rvalid) cf_hold_q <= ram_ctx;
    end
  end

  rd_tag_pipe #(.DEPTH(RD_LAT + 1)) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign lk_rvalid   = tag_out.vld && tag_out.owner == TAG_LK;
  assign cf_rvalid   = tag_out.vld && tag_out.owner == TAG_CF;
  assign lk_rdata    = lk_rvalid ? ram_ctx : lk_hold_q;
  assign cf_rdata    = cf_rvalid ? ram_ctx : cf_hold_q;
  assign ram_idx     = idx_q;
  assign ram_rdValid = rd_q;
  assign ram_wrValid = wr_q;
  assign ram_data    = data_q;
  assign starve_cnt  = starve_q;

endmodule
